// File: rtl/rpn_pkg.sv
// Shared opcode/error encodings and helpers for the RPN stack calculator.
// Latency: n/a (constants, types and pure functions only).
// Backpressure: n/a.
package rpn_pkg;

  localparam logic [4:0] OP_ADD  = 5'h00;
  localparam logic [4:0] OP_SUB  = 5'h01;
  localparam logic [4:0] OP_MUL  = 5'h02;
  localparam logic [4:0] OP_SHL  = 5'h03;
  localparam logic [4:0] OP_SHR  = 5'h04;
  localparam logic [4:0] OP_BAND = 5'h05;
  localparam logic [4:0] OP_BOR  = 5'h06;
  localparam logic [4:0] OP_BXOR = 5'h07;
  localparam logic [4:0] OP_AND  = 5'h08;
  localparam logic [4:0] OP_OR   = 5'h09;
  localparam logic [4:0] OP_EQ   = 5'h0A;
  localparam logic [4:0] OP_NE   = 5'h0B;
  localparam logic [4:0] OP_GE   = 5'h0C;
  localparam logic [4:0] OP_LE   = 5'h0D;
  localparam logic [4:0] OP_GT   = 5'h0E;
  localparam logic [4:0] OP_LT   = 5'h0F;
  localparam logic [4:0] OP_NEG  = 5'h10;
  localparam logic [4:0] OP_BNOT = 5'h11;
  localparam logic [4:0] OP_NOT  = 5'h12;

  localparam logic [2:0] ERR_NONE  = 3'd0;
  localparam logic [2:0] ERR_OVF   = 3'd1;
  localparam logic [2:0] ERR_UNF   = 3'd2;
  localparam logic [2:0] ERR_BADOP = 3'd3;
  localparam logic [2:0] ERR_BOTH  = 3'd4;

  typedef enum logic {M_IDLE, M_RUN} mul_state_t;

  // Bit 4 selects the unary group (NEG/BNOT/NOT).
  function automatic logic is_unary(input logic [4:0] opc);
    return opc[4];
  endfunction

  // 0x13..0x1F are unassigned.
  function automatic logic is_valid_op(input logic [4:0] opc);
    return opc <= OP_NOT;
  endfunction

endpackage

// File: rtl/rpn_stack_calc_if.sv
// Token-side request bundle and stack status outputs of the RPN calculator.
// Latency: n/a (wires only).
// Backpressure: master must hold num/op/x while ready=0.
interface rpn_stack_calc_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
);
  localparam int DW = $clog2(DEPTH + 1);

  logic             num;
  logic             op;
  logic [WIDTH-1:0] x;
  logic             clr;
  logic             ready;
  logic             busy;
  logic [WIDTH-1:0] qtop;
  logic [WIDTH-1:0] qnext;
  logic [DW-1:0]    depth;
  logic             err;
  logic [2:0]       err_code;

  modport master (
    output num, op, x, clr,
    input  ready, busy, qtop, qnext, depth, err, err_code
  );

  modport slave (
    input  num, op, x, clr,
    output ready, busy, qtop, qnext, depth, err, err_code
  );
endinterface

// File: rtl/rpn_mul.sv
// Iterative shift-add multiplier, low WIDTH bits of a*b.
// Latency: done asserts combinationally in the WIDTH-th cycle after start.
// Backpressure: start is only honoured while idle; busy covers the run.
module rpn_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] p
);
  import rpn_pkg::*;

  localparam int CW = $clog2(WIDTH + 1);

  mul_state_t       state, state_nx;
  logic [WIDTH-1:0] acc, ma, mb;
  logic [CW-1:0]    cnt;

  // Final iteration is folded into the output so the product lands on the WIDTH-th edge.
  assign p = acc + (mb[0] ? ma : '0);

  // State register; reset aborts any multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) state <= M_IDLE;
    else     state <= state_nx;
  end

  // Next state and status strobes.
  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    case (state)
      M_IDLE: if (start) state_nx = M_RUN;
      M_RUN: begin
        busy = 1'b1;
        if (cnt == CW'(1)) begin
          done     = 1'b1;
          state_nx = M_IDLE;
        end
      end
      default: state_nx = M_IDLE;
    endcase
  end

  // Operand latch on start, then one partial product per cycle.
  always_ff @(posedge clk) begin
    if (start && state == M_IDLE) begin
      acc <= '0;
      ma  <= a;
      mb  <= b;
      cnt <= CW'(WIDTH);
    end else if (state == M_RUN) begin
      acc <= p;
      ma  <= ma << 1;
      mb  <= mb >> 1;
      cnt <= cnt - CW'(1);
    end
  end

endmodule

// File: rtl/rpn_stack_calc.sv
// RPN operand stack with inline single-cycle ALU and iterative multiplier.
// Latency: 1 edge for all ops except MUL, which commits WIDTH edges after accept.
// Backpressure: ready=~busy; requests while busy are ignored, source holds them.
module rpn_stack_calc #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst,
  rpn_stack_calc_if.slave   bus
);
  import rpn_pkg::*;

  localparam int DW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] stk [DEPTH];
  logic [DW-1:0]    dep;
  logic             err_q;
  logic [2:0]       code_q;

  logic [AW-1:0]    top_i, nxt_i, push_i;
  logic [WIDTH-1:0] a, b, alu_res, mul_p;
  logic [4:0]       opc;
  logic             busy, accept, mul_done, mul_start;
  logic             do_push, do_unary, do_binary, err_hit;
  logic [2:0]       err_new;

  // Entry 0 is the bottom; the top lives at depth-1.
  assign top_i  = AW'(dep - DW'(1));
  assign nxt_i  = AW'(dep - DW'(2));
  assign push_i = AW'(dep);
  assign b      = (dep != '0)      ? stk[top_i] : '0;
  assign a      = (dep >= DW'(2))  ? stk[nxt_i] : '0;
  assign opc    = bus.x[4:0];
  assign accept = !busy && (bus.num || bus.op);

  // Single-cycle ALU: a is the older entry, b the newer.
  always_comb begin
    alu_res = '0;
    case (opc)
      OP_ADD:  alu_res = a + b;
      OP_SUB:  alu_res = a - b;
      OP_SHL:  alu_res = a << b;
      OP_SHR:  alu_res = a >> b;
      OP_BAND: alu_res = a & b;
      OP_BOR:  alu_res = a | b;
      OP_BXOR: alu_res = a ^ b;
      OP_AND:  alu_res = {{(WIDTH-1){1'b0}}, (a != '0) && (b != '0)};
      OP_OR:   alu_res = {{(WIDTH-1){1'b0}}, (a != '0) || (b != '0)};
      OP_EQ:   alu_res = {{(WIDTH-1){1'b0}}, a == b};
      OP_NE:   alu_res = {{(WIDTH-1){1'b0}}, a != b};
      OP_GE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) >= $signed(b)};
      OP_LE:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <= $signed(b)};
      OP_GT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) >  $signed(b)};
      OP_LT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(a) <  $signed(b)};
      OP_NEG:  alu_res = {WIDTH{1'b0}} - b;
      OP_BNOT: alu_res = ~b;
      OP_NOT:  alu_res = {{(WIDTH-1){1'b0}}, b == '0};
      default: alu_res = '0;
    endcase
  end

  // Request decode: pick exactly one stack action or one error code.
  always_comb begin
    do_push   = 1'b0;
    do_unary  = 1'b0;
    do_binary = 1'b0;
    mul_start = 1'b0;
    err_hit   = 1'b0;
    err_new   = ERR_NONE;
    if (accept) begin
      if (bus.num && bus.op) begin
        err_hit = 1'b1; err_new = ERR_BOTH;
      end else if (bus.num) begin
        if (dep == DW'(DEPTH)) begin
          err_hit = 1'b1; err_new = ERR_OVF;
        end else do_push = 1'b1;
      end else if (!is_valid_op(opc)) begin
        err_hit = 1'b1; err_new = ERR_BADOP;
      end else if (is_unary(opc)) begin
        if (dep == '0) begin
          err_hit = 1'b1; err_new = ERR_UNF;
        end else do_unary = 1'b1;
      end else if (dep < DW'(2)) begin
        err_hit = 1'b1; err_new = ERR_UNF;
      end else if (opc == OP_MUL) mul_start = 1'b1;
      else do_binary = 1'b1;
    end
  end

  rpn_mul #(.WIDTH(WIDTH)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (mul_done),
    .p     (mul_p)
  );

  // Stack storage and depth; the multiplier result retires the two operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      dep <= '0;
    end else if (mul_done) begin
      stk[nxt_i] <= mul_p;
      dep        <= dep - DW'(1);
    end else if (do_push) begin
      stk[push_i] <= bus.x;
      dep         <= dep + DW'(1);
    end else if (do_unary) begin
      stk[top_i] <= alu_res;
    end else if (do_binary) begin
      stk[nxt_i] <= alu_res;
      dep        <= dep - DW'(1);
    end
  end

  // Sticky first-error capture; a fresh error beats a same-edge clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end else if (err_hit && (!err_q || bus.clr)) begin
      err_q  <= 1'b1;
      code_q <= err_new;
    end else if (bus.clr) begin
      err_q  <= 1'b0;
      code_q <= ERR_NONE;
    end
  end

  assign bus.ready    = !busy;
  assign bus.busy     = busy;
  assign bus.qtop     = b;
  assign bus.qnext    = a;
  assign bus.depth    = dep;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;

endmodule
